// File: rtl/ddrx_mc_pkg.sv
// Types and constants shared by the DDR memory-controller blocks.
package ddrx_mc_pkg;

  localparam int unsigned JEDEC_MAX_POSTPONE = 8;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    BUSY
  } ref_state_e;

endpackage

// File: rtl/ref_interval_timer.sv
// tREFI down-counter: one-cycle tick every 'period' cycles while running.
module ref_interval_timer #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         run,
  input  logic [W-1:0] period,
  output logic         tick
);

  localparam logic [W-1:0] One = W'(1);

  logic [W-1:0] cnt_q;
  logic         primed_q;

  // The first running cycle only loads, so the first tick lands a full period later.
  assign tick = run && primed_q && (cnt_q == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q    <= '0;
      primed_q <= 1'b0;
    end else begin
      primed_q <= run;
      if (!run || !primed_q || (cnt_q == '0)) begin
        cnt_q <= period - One;
      end else begin
        cnt_q <= cnt_q - One;
      end
    end
  end

endmodule

// File: rtl/ref_scheduler.sv
// Auto-refresh scheduler: owed-refresh accounting, req/ack handshake and tRFC blackout.
module ref_scheduler
  import ddrx_mc_pkg::*;
#(
  parameter int unsigned C_TREFI_WIDTH  = 16,
  parameter int unsigned C_TRFC_WIDTH   = 10,
  parameter int unsigned C_MAX_POSTPONE = JEDEC_MAX_POSTPONE,
  parameter int unsigned C_PEND_WIDTH   = 4
) (
  input  logic                     core_clk,
  input  logic                     core_arst,
  input  logic                     ref_en,
  input  logic [C_TREFI_WIDTH-1:0] cfg_trefi,
  input  logic [C_TRFC_WIDTH-1:0]  cfg_trfc,
  output logic                     ref_req,
  input  logic                     ref_ack,
  output logic                     ref_busy,
  output logic                     ref_done,
  output logic                     ref_urgent,
  output logic [C_PEND_WIDTH-1:0]  ref_pending,
  output logic                     ref_err
);

  localparam logic [C_PEND_WIDTH-1:0] PendMax = C_PEND_WIDTH'(C_MAX_POSTPONE);
  localparam logic [C_PEND_WIDTH-1:0] PendUrg = C_PEND_WIDTH'(C_MAX_POSTPONE - 1);
  localparam logic [C_PEND_WIDTH-1:0] PendOne = C_PEND_WIDTH'(1);
  localparam logic [C_TRFC_WIDTH-1:0] TrfcOne = C_TRFC_WIDTH'(1);

  ref_state_e              state_q;
  logic [C_TRFC_WIDTH-1:0] trfc_q;
  logic [C_TRFC_WIDTH-1:0] trfc_load;
  logic [C_PEND_WIDTH-1:0] pending_d;
  logic                    tick;
  logic                    ack_acc;
  logic                    err_set;

  ref_interval_timer #(
    .W(C_TREFI_WIDTH)
  ) u_timer (
    .clk    (core_clk),
    .rst    (core_arst),
    .run    (ref_en && (cfg_trefi != '0)),
    .period (cfg_trefi),
    .tick   (tick)
  );

  assign ack_acc   = ref_ack && ref_req;
  assign err_set   = tick && !ack_acc && (ref_pending == PendMax);
  assign trfc_load = (cfg_trfc == '0) ? '0 : cfg_trfc - TrfcOne;

  always_comb begin
    pending_d = ref_pending;
    if (tick && !ack_acc && (ref_pending != PendMax)) begin
      pending_d = ref_pending + PendOne;
    end else if (ack_acc && !tick) begin
      pending_d = ref_pending - PendOne;
    end
  end

  always_ff @(posedge core_clk or posedge core_arst) begin
    if (core_arst) begin
      state_q     <= IDLE;
      trfc_q      <= '0;
      ref_pending <= '0;
      ref_urgent  <= 1'b0;
      ref_err     <= 1'b0;
      ref_req     <= 1'b0;
      ref_busy    <= 1'b0;
      ref_done    <= 1'b0;
    end else begin
      ref_pending <= pending_d;
      ref_urgent  <= (pending_d >= PendUrg);
      if (err_set) begin
        ref_err <= 1'b1;
      end
      unique case (state_q)
        IDLE: begin
          if (pending_d != '0) begin
            state_q <= REQ;
            ref_req <= 1'b1;
          end
        end
        REQ: begin
          if (ack_acc) begin
            state_q  <= BUSY;
            ref_req  <= 1'b0;
            ref_busy <= 1'b1;
            trfc_q   <= trfc_load;
            ref_done <= (trfc_load == '0);
          end
        end
        BUSY: begin
          if (trfc_q == '0) begin
            ref_busy <= 1'b0;
            ref_done <= 1'b0;
            if (pending_d != '0) begin
              state_q <= REQ;
              ref_req <= 1'b1;
            end else begin
              state_q <= IDLE;
            end
          end else begin
            trfc_q   <= trfc_q - TrfcOne;
            // Registered pulse must be armed one cycle before the count reaches zero.
            ref_done <= (trfc_q == TrfcOne);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ref_scheduler.sv
// Directed bench for ref_scheduler; samples on the falling edge, drives for the next rising edge.
module tb_ref_scheduler;

  logic        core_clk = 1'b0;
  logic        core_arst;
  logic        ref_en;
  logic [15:0] cfg_trefi;
  logic [9:0]  cfg_trfc;
  logic        ref_req;
  logic        ref_ack;
  logic        ref_busy;
  logic        ref_done;
  logic        ref_urgent;
  logic [3:0]  ref_pending;
  logic        ref_err;

  int nvec = 0;
  int nerr = 0;
  int cyc  = 0;

  ref_scheduler dut (
    .core_clk    (core_clk),
    .core_arst   (core_arst),
    .ref_en      (ref_en),
    .cfg_trefi   (cfg_trefi),
    .cfg_trfc    (cfg_trfc),
    .ref_req     (ref_req),
    .ref_ack     (ref_ack),
    .ref_busy    (ref_busy),
    .ref_done    (ref_done),
    .ref_urgent  (ref_urgent),
    .ref_pending (ref_pending),
    .ref_err     (ref_err)
  );

  always #5 core_clk = ~core_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge core_clk);
    @(negedge core_clk);
    cyc++;
  endtask

  // Leaves the bench at a falling edge with reset released and cyc = 0.
  task automatic do_reset();
    core_arst = 1'b1;
    step();
    step();
    core_arst = 1'b0;
    cyc = 0;
  endtask

  initial begin : main
    int n;
    int bl;
    int dn_at;
    int maxp;
    int urg_p;
    bit urg_seen;
    int busy_n, req_n, done_n, rises, run_len, max_run;
    bit prev_b;

    core_arst = 1'b1;
    ref_en    = 1'b0;
    cfg_trefi = 16'd0;
    cfg_trfc  = 10'd0;
    ref_ack   = 1'b0;
    #1;
    check("rst_req", ref_req, 0);
    check("rst_busy", ref_busy, 0);
    check("rst_done", ref_done, 0);
    check("rst_urgent", ref_urgent, 0);
    check("rst_pending", ref_pending, 0);
    check("rst_err", ref_err, 0);

    // Basic cadence: tREFI=100, tRFC=20, ack two cycles after req is seen.
    ref_en    = 1'b1;
    cfg_trefi = 16'd100;
    cfg_trfc  = 10'd20;
    do_reset();
    maxp = 0;
    for (int r = 0; r < 3; r++) begin
      n = 0;
      while (!ref_req && n < 300) begin
        step();
        n++;
        if (ref_pending > maxp) maxp = ref_pending;
      end
      check("a_req_rise_cycle", cyc, 101 + 100 * r);
      step();
      step();
      ref_ack = 1'b1;
      step();
      ref_ack = 1'b0;
      check("a_pending_after_ack", ref_pending, 0);
      bl    = 0;
      dn_at = 0;
      while (ref_busy && bl < 100) begin
        bl++;
        if (ref_done) dn_at = bl;
        if (ref_pending > maxp) maxp = ref_pending;
        step();
      end
      check("a_busy_len", bl, 20);
      check("a_done_last_busy", dn_at, 20);
    end
    check("a_max_pending", maxp, 1);

    // Postponement to the limit, no ack; tREFI raised mid-way to take effect at the next reload.
    cfg_trefi = 16'd10;
    do_reset();
    urg_seen = 1'b0;
    urg_p    = 0;
    for (int i = 1; i <= 91; i++) begin
      step();
      if (ref_urgent && !urg_seen) begin
        urg_seen = 1'b1;
        urg_p    = ref_pending;
      end
      if (i == 85) begin
        check("b_pending_8", ref_pending, 8);
        check("b_err_before_9th", ref_err, 0);
        check("b_urgent_at_8", ref_urgent, 1);
        cfg_trefi = 16'd1000;
      end
    end
    check("b_urgent_rise_pending", urg_p, 7);
    check("b_pending_sat", ref_pending, 8);
    check("b_err_set", ref_err, 1);
    check("b_req_held", ref_req, 1);

    // Drain 8 with ack held, tRFC=4.
    cfg_trfc = 10'd4;
    ref_ack  = 1'b1;
    busy_n = 0; req_n = 0; done_n = 0; rises = 0; run_len = 0; max_run = 0; prev_b = 1'b0;
    for (int i = 0; i < 49; i++) begin
      step();
      if (ref_busy) begin
        busy_n++;
        run_len++;
        if (run_len > max_run) max_run = run_len;
        if (!prev_b) rises++;
      end else begin
        run_len = 0;
      end
      if (ref_req) req_n++;
      if (ref_done) done_n++;
      prev_b = ref_busy;
    end
    ref_ack = 1'b0;
    check("c_refreshes", rises, 8);
    check("c_busy_cycles", busy_n, 32);
    check("c_max_busy_run", max_run, 4);
    check("c_req_gaps", req_n, 7);
    check("c_done_pulses", done_n, 8);
    check("c_pending_end", ref_pending, 0);
    check("c_req_end", ref_req, 0);
    check("c_urgent_end", ref_urgent, 0);
    check("c_err_sticky", ref_err, 1);

    // Simultaneous tick and ack at pending=2.
    cfg_trefi = 16'd10;
    cfg_trfc  = 10'd3;
    do_reset();
    check("d_err_cleared", ref_err, 0);
    while (cyc < 30) step();
    check("d_pending_pre", ref_pending, 2);
    check("d_req_pre", ref_req, 1);
    ref_ack = 1'b1;
    step();
    ref_ack = 1'b0;
    check("d_pending_same", ref_pending, 2);
    check("d_busy", ref_busy, 1);
    check("d_req_low_busy", ref_req, 0);

    // Disabled timer with 3 owed, tRFC=0 gives 1-cycle blackouts.
    while (cyc < 41) step();
    check("e_pending_3", ref_pending, 3);
    ref_en   = 1'b0;
    cfg_trfc = 10'd0;
    ref_ack  = 1'b1;
    busy_n = 0; done_n = 0; run_len = 0; max_run = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (ref_busy) begin
        busy_n++;
        run_len++;
        if (run_len > max_run) max_run = run_len;
      end else begin
        run_len = 0;
      end
      if (ref_done) done_n++;
    end
    ref_ack = 1'b0;
    check("e_busy_cycles", busy_n, 3);
    check("e_done_pulses", done_n, 3);
    check("e_max_busy_run", max_run, 1);
    check("e_pending_end", ref_pending, 0);
    ref_en    = 1'b1;
    cfg_trefi = 16'd0;
    for (int i = 0; i < 30; i++) step();
    check("e_trefi0_pending", ref_pending, 0);
    check("e_trefi0_req", ref_req, 0);

    // Spurious ack in IDLE, then asynchronous reset mid-blackout.
    ref_ack = 1'b1;
    step();
    ref_ack = 1'b0;
    check("f_spurious_pending", ref_pending, 0);
    check("f_spurious_busy", ref_busy, 0);
    cfg_trefi = 16'd5;
    cfg_trfc  = 10'd20;
    n = 0;
    while (!ref_req && n < 50) begin
      step();
      n++;
    end
    check("f_req_seen", ref_req, 1);
    ref_ack = 1'b1;
    step();
    ref_ack = 1'b0;
    check("f_busy_before_rst", ref_busy, 1);
    step();
    step();
    #2 core_arst = 1'b1;
    #1;
    check("f_async_busy", ref_busy, 0);
    check("f_async_req", ref_req, 0);
    check("f_async_done", ref_done, 0);
    check("f_async_pending", ref_pending, 0);
    check("f_async_urgent", ref_urgent, 0);
    @(negedge core_clk);
    core_arst = 1'b0;
    step();
    check("f_post_rst_busy", ref_busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/ref_scheduler.md
Name: ref_scheduler

Overview:
- Generates DDR auto-refresh demand for the core clock domain and sits directly upstream of main_control, which issues the REF command on the DFI.
- A tREFI interval timer accumulates owed refreshes, and main_control drains them through a req/ack handshake.
- After each granted refresh the block enforces a tRFC blackout.
- Postponement is tracked up to the JEDEC limit, with an urgency flag and a sticky overflow error.

Parameters:
- C_TREFI_WIDTH, 16, width of the tREFI interval in core_clk cycles.
- C_TRFC_WIDTH, 10, width of the tRFC blackout in core_clk cycles.
- C_MAX_POSTPONE, 8, maximum owed refreshes; the pending counter saturates here.
- C_PEND_WIDTH, 4, pending counter width; must satisfy 2^C_PEND_WIDTH > C_MAX_POSTPONE.

Ports:
- core_clk  in  1  core clock.
- core_arst  in  1  asynchronous, active-high reset.
- ref_en  in  1  enables interval counting; driven high by main_control after ddr_init_done.
- cfg_trefi  in  C_TREFI_WIDTH  refresh interval in cycles; 0 means timer disabled.
- cfg_trfc  in  C_TRFC_WIDTH  refresh-to-valid delay in cycles; 0 is treated as 1.
- ref_req  out  1  one or more refreshes owed; main_control should issue REF.
- ref_ack  in  1  main_control has issued REF this cycle.
- ref_busy  out  1  tRFC blackout in progress; no commands permitted to the rank.
- ref_done  out  1  one-cycle pulse on the last blackout cycle.
- ref_urgent  out  1  pending >= C_MAX_POSTPONE-1; main_control must prioritise refresh.
- ref_pending  out  C_PEND_WIDTH  current owed-refresh count.
- ref_err  out  1  sticky flag: a tick arrived while pending was already at C_MAX_POSTPONE.

Behaviour:
- Reset (asynchronous, core_arst=1):
  - all outputs 0, FSM=IDLE, pending=0, ref_err=0.
  - interval counter=0, and it reloads on the first enabled cycle.
- Interval timer:
  - Runs while ref_en=1 and cfg_trefi!=0; it is a down-counter loaded with cfg_trefi-1.
  - At 0 it produces a one-cycle tick and reloads with cfg_trefi-1. The tick period is therefore exactly cfg_trefi cycles.
  - While ref_en=0 or cfg_trefi=0: counter held at reload value, no ticks. Pending still drains normally.
  - A cfg_trefi change takes effect at the next reload only.
- Pending counter:
  - tick alone: +1.
  - ack accepted alone: -1.
  - tick and ack in the same cycle: unchanged.
  - tick with pending==C_MAX_POSTPONE and no ack: pending stays, ref_err set (sticky until reset).
- FSM states: IDLE, REQ, BUSY.
  - IDLE -> REQ when pending>0.
  - In REQ, ref_req=1 (registered, asserted the cycle after entering REQ's condition). ref_ack is accepted only when ref_req=1.
  - On an accepted ack: pending decremented, tRFC counter loaded with max(cfg_trfc,1)-1, next state BUSY.
  - ref_ack while ref_req=0 is ignored and has no effect.
  - In BUSY: ref_busy=1 and ref_req=0. The counter decrements each cycle.
  - At count 0: ref_done=1 for that cycle, then go to REQ if pending>0, else IDLE.
  - Blackout length: ref_busy is high for exactly max(cfg_trfc,1) cycles, starting the cycle after the ack.
- ref_urgent and ref_pending are registered and reflect the post-update pending value.
- Back-to-back refreshes: with pending>1 after a blackout, ref_req re-asserts on the cycle after ref_done. There is no idle gap beyond that.
- Reset mid-BUSY: immediate return to IDLE and all state cleared. Main_control re-runs init.

Decomposition:
- Shared package ddrx_mc_pkg: ref_state_e enum (IDLE, REQ, BUSY) and localparam JEDEC_MAX_POSTPONE=8.
- One sub-module is natural: ref_interval_timer (load/decrement/tick down-counter). The FSM and pending logic stay in ref_scheduler.

Test Plan:
- Basic cadence:
  - Stimulus: cfg_trefi=100, cfg_trfc=20, ref_en=1, ack 3 cycles after each ref_req.
  - Required: ticks every 100 cycles; ref_busy 20 cycles per refresh; ref_done pulses aligned to the last busy cycle; pending never exceeds 1.
- Postponement to limit:
  - Stimulus: cfg_trefi=10, never ack, 90 cycles.
  - Required: pending reaches 8; ref_urgent rises when pending=7; the 9th tick sets ref_err and pending stays 8.
- Drain:
  - Stimulus: from pending=8, hold ref_ack=1 continuously with cfg_trfc=4 and cfg_trefi=1000.
  - Required: 8 refreshes, each with 4 busy cycles and 1 req cycle between them; pending reaches 0; then IDLE with ref_req=0.
- Simultaneous events:
  - Stimulus: pending=2, ack coincides with tick.
  - Required: pending stays 2; FSM enters BUSY.
- Disable and zero values:
  - Stimulus: ref_en=0 with pending=3; separately cfg_trefi=0 and cfg_trfc=0.
  - Required: no new ticks but all 3 refreshes still drain; cfg_trfc=0 gives a 1-cycle blackout.
- Spurious ack and async reset:
  - Stimulus: pulse ref_ack while IDLE; then assert core_arst mid-BUSY between clock edges.
  - Required: spurious ack leaves pending unchanged; on reset, outputs drop to 0 immediately without waiting for a clock edge.
